// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-side types and constants for the instruction memory responder
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/imem_byte_loader.sv
// rtl/imem_byte_loader.sv - byte-serial boot loader: assembles big-endian words and issues array writes
module imem_byte_loader
  import cpu_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loading,
  input  logic              ldValid,
  input  logic [7:0]        ldByte,
  input  logic              ldLast,
  output logic              wrEn,
  output logic [AW-1:0]     wrAddr,
  output logic [WORD_W-1:0] wrData,
  output logic              loadEnd
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [23:0]   shiftReg;
  logic [1:0]    byteCnt;
  logic [AW-1:0] wptr;
  logic          accept;

  assign accept = loading & ldValid;

  // Earlier bytes sit in the low end of shiftReg; the incoming byte lands after them and the rest pads with zero.
  always_comb begin
    wrData = '0;
    case (byteCnt)
      2'd0:    wrData = {ldByte, 24'h0};
      2'd1:    wrData = {shiftReg[7:0], ldByte, 16'h0};
      2'd2:    wrData = {shiftReg[15:0], ldByte, 8'h0};
      default: wrData = {shiftReg[23:0], ldByte};
    endcase
  end

  assign wrEn    = accept & (ldLast | (byteCnt == 2'd3));
  assign wrAddr  = wptr;
  assign loadEnd = wrEn & (ldLast | (wptr == LAST_IDX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shiftReg <= '0;
      byteCnt  <= '0;
      wptr     <= '0;
    end else if (accept) begin
      if (wrEn) begin
        shiftReg <= '0;
        byteCnt  <= '0;
        wptr     <= wptr + AW'(1);
      end else begin
        shiftReg <= {shiftReg[15:0], ldByte};
        byteCnt  <= byteCnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - boot-loaded instruction memory with registered fetch port (IMEM_ADDR_CHECK_EN adds addr_err)
module inst_mem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       addr,
  output logic              req_ready,
  output logic [WORD_W-1:0] rdata,
  output logic              rsp_valid,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
`ifdef IMEM_ADDR_CHECK_EN
  output logic              addr_err,
`endif
  output logic              load_done
);

  localparam int AW = $clog2(DEPTH);

  fetch_state_e      state;
  logic              wrEn;
  logic [AW-1:0]     wrAddr;
  logic [WORD_W-1:0] wrData;
  logic              loadEnd;
  logic              accept;
  logic [AW-1:0]     index;
  logic [WORD_W-1:0] mem [DEPTH];

  imem_byte_loader #(
    .DEPTH(DEPTH)
  ) u_loader (
    .clk    (clk),
    .rst    (rst),
    .loading(state == LOAD),
    .ldValid(ld_valid),
    .ldByte (ld_byte),
    .ldLast (ld_last),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (wrData),
    .loadEnd(loadEnd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
    end else if (state == LOAD && loadEnd) begin
      state <= SERVE;
    end
  end

  assign ld_ready  = (state == LOAD);
  assign req_ready = (state == SERVE);
  assign load_done = (state == SERVE);

  assign accept = ce & req_ready;
  assign index  = addr[AW+1:2];

  // Array contents survive reset so a warm reset does not need a full image to run.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

`ifdef IMEM_ADDR_CHECK_EN
  logic badAddr;

  assign badAddr = (|addr[1:0]) | (|addr[31:AW+2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rdata     <= '0;
      addr_err  <= 1'b0;
    end else begin
      rsp_valid <= accept;
      addr_err  <= accept & badAddr;
      if (accept) begin
        rdata <= badAddr ? NOP_INST : mem[index];
      end else begin
        rdata <= '0;
      end
    end
  end
`else
  logic unusedAddrBits;

  // Byte offset and upper address bits alias into the array.
  assign unusedAddrBits = ^{addr[31:AW+2], addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rdata     <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rdata <= mem[index];
      end else begin
        rdata <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - directed scoreboard bench for inst_mem_responder (DEPTH 1024 and 4)
module tb_inst_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;

  logic        ce, ldValid, ldLast;
  logic [31:0] addr;
  logic [7:0]  ldByte;
  logic        reqReady, rspValid, ldReady, loadDone;
  logic [31:0] rdata;

  logic        ce4, ldValid4, ldLast4;
  logic [31:0] addr4;
  logic [7:0]  ldByte4;
  logic        reqReady4, rspValid4, ldReady4, loadDone4;
  logic [31:0] rdata4;

`ifdef IMEM_ADDR_CHECK_EN
  logic addrErr, addrErr4;
`endif

  exp_t q[$];
  exp_t q4[$];
  int   nCompared = 0;
  int   nMismatch = 0;

  inst_mem_responder #(.DEPTH(1024)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .addr     (addr),
    .req_ready(reqReady),
    .rdata    (rdata),
    .rsp_valid(rspValid),
    .ld_valid (ldValid),
    .ld_byte  (ldByte),
    .ld_last  (ldLast),
    .ld_ready (ldReady),
`ifdef IMEM_ADDR_CHECK_EN
    .addr_err (addrErr),
`endif
    .load_done(loadDone)
  );

  inst_mem_responder #(.DEPTH(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce4),
    .addr     (addr4),
    .req_ready(reqReady4),
    .rdata    (rdata4),
    .rsp_valid(rspValid4),
    .ld_valid (ldValid4),
    .ld_byte  (ldByte4),
    .ld_last  (ldLast4),
    .ld_ready (ldReady4),
`ifdef IMEM_ADDR_CHECK_EN
    .addr_err (addrErr4),
`endif
    .load_done(loadDone4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkRsp();
    exp_t e;
    chk("rsp_valid", {31'b0, rspValid}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("rdata", rdata, e.data);
`ifdef IMEM_ADDR_CHECK_EN
      chk("addr_err", {31'b0, addrErr}, {31'b0, e.err});
`endif
    end else begin
      chk("rdata_idle", rdata, 32'h0);
    end
    chk("rsp_valid4", {31'b0, rspValid4}, {31'b0, q4.size() != 0});
    if (q4.size() != 0) begin
      e = q4.pop_front();
      chk("rdata4", rdata4, e.data);
`ifdef IMEM_ADDR_CHECK_EN
      chk("addr_err4", {31'b0, addrErr4}, {31'b0, e.err});
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    checkRsp();
  endtask

  task automatic doReset();
    rst = 1'b0;
    ce = 0; ldValid = 0; ldLast = 0; ldByte = 0; addr = 0;
    ce4 = 0; ldValid4 = 0; ldLast4 = 0; ldByte4 = 0; addr4 = 0;
    q.delete();
    q4.delete();
    #2;
    chk("rst_req_ready", {31'b0, reqReady}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rspValid}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ld_ready", {31'b0, ldReady}, 32'd1);
    chk("rst_load_done", {31'b0, loadDone}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic last);
    chk("ld_ready", {31'b0, ldReady}, 32'd1);
    ldValid = 1; ldByte = b; ldLast = last;
    cycle();
    ldValid = 0; ldLast = 0;
  endtask

  task automatic sendByte4(input logic [7:0] b, input logic expReady);
    chk("ld_ready4", {31'b0, ldReady4}, {31'b0, expReady});
    ldValid4 = 1; ldByte4 = b; ldLast4 = 0;
    cycle();
    ldValid4 = 0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic err);
    ce = 1; addr = a;
    q.push_back('{data: d, err: err});
    cycle();
    ce = 0;
  endtask

  task automatic fetch4(input logic [31:0] a, input logic [31:0] d, input logic err);
    ce4 = 1; addr4 = a;
    q4.push_back('{data: d, err: err});
    cycle();
    ce4 = 0;
  endtask

  initial begin
    logic [7:0] img1 [8];
    logic [7:0] b;
    img1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    // Test 1: two full words
    doReset();
    for (int i = 0; i < 8; i++) sendByte(img1[i], i == 7);
    chk("t1_load_done", {31'b0, loadDone}, 32'd1);
    chk("t1_req_ready", {31'b0, reqReady}, 32'd1);
    chk("t1_ld_ready", {31'b0, ldReady}, 32'd0);
    fetch(32'h4, 32'h5566_7788, 1'b0);
    fetch(32'h0, 32'h1122_3344, 1'b0);
    cycle();

    // Test 2: partial last word zero-padded
    doReset();
    sendByte(8'hAA, 0); sendByte(8'hBB, 0); sendByte(8'hCC, 0);
    sendByte(8'hDD, 0); sendByte(8'hEE, 0);
    chk("t2_load_pending", {31'b0, loadDone}, 32'd0);
    sendByte(8'hFF, 1);
    chk("t2_load_done", {31'b0, loadDone}, 32'd1);
    fetch(32'h4, 32'hEEFF_0000, 1'b0);
    fetch(32'h0, 32'hAABB_CCDD, 1'b0);

    // Test 3: fetch ignored during load, then back-to-back fetches
    doReset();
    ce = 1; addr = 32'h0;
    chk("t3_req_ready_load", {31'b0, reqReady}, 32'd0);
    cycle();
    cycle();
    ce = 0;
    for (int i = 0; i < 12; i++) begin
      b = 8'hA0 + 8'(i);
      sendByte(b, i == 11);
    end
    fetch(32'h0, 32'hA0A1_A2A3, 1'b0);
    fetch(32'h4, 32'hA4A5_A6A7, 1'b0);
    fetch(32'h8, 32'hA8A9_AAAB, 1'b0);
    cycle();

    // Test 4: DEPTH=4 fills without ld_last, extra bytes refused
    doReset();
    for (int i = 1; i <= 20; i++) begin
      sendByte4(8'(i), i <= 16);
      if (i == 15) chk("t4_not_full", {31'b0, loadDone4}, 32'd0);
      if (i == 16) chk("t4_full", {31'b0, loadDone4}, 32'd1);
    end
    fetch4(32'hC, 32'h0D0E_0F10, 1'b0);
    fetch4(32'h8, 32'h090A_0B0C, 1'b0);
    fetch4(32'h0, 32'h0102_0304, 1'b0);
`ifdef IMEM_ADDR_CHECK_EN
    fetch4(32'h10, 32'h0, 1'b1);
`else
    fetch4(32'h10, 32'h0102_0304, 1'b0);
`endif

    // Test 5: reset mid-load discards partial word
    sendByte(8'hDE, 0);
    sendByte(8'hAD, 0);
    doReset();
    sendByte(8'h01, 0); sendByte(8'h02, 0); sendByte(8'h03, 0); sendByte(8'h04, 1);
    chk("t5_load_done", {31'b0, loadDone}, 32'd1);
    fetch(32'h0, 32'h0102_0304, 1'b0);

    // Test 6: address checking / aliasing
`ifdef IMEM_ADDR_CHECK_EN
    fetch(32'h2, 32'h0, 1'b1);
    fetch(32'h1000, 32'h0, 1'b1);
    fetch(32'h0, 32'h0102_0304, 1'b0);
`else
    fetch(32'h1000, 32'h0102_0304, 1'b0);
    fetch(32'h3, 32'h0102_0304, 1'b0);
`endif
    cycle();

    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("queue4_drained", 32'(q4.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
